// File: rtl/vga_pkg.sv
// Shared timing constants, window defaults and pixel types for the VGA frame fetcher.
// Horizontal timing is fixed at 640x480@60; vertical defaults can be overridden per instance.
package vga_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned WIN_W  = 200;
    localparam int unsigned WIN_H  = 200;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 10;

    localparam logic [ADDR_W-1:0] ADDR_NONE = 16'hFFFF;

    // Field order mirrors pix_data[23:0]: red in the low byte.
    typedef struct packed {
        logic [7:0] blue;
        logic [7:0] green;
        logic [7:0] red;
    } rgb_t;

    function automatic logic in_span(input logic [CNT_W-1:0] x,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_frame_fetch_if.sv
// Bundle of the memory read port and DAC-side signals of the frame fetcher.
interface vga_frame_fetch_if;
    import vga_pkg::*;

    logic [31:0]       pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              vga_clk;
    logic              hsync_n;
    logic              vsync_n;
    logic              blank_n;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              frame_start;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;

    modport master (
        input  pix_data,
        output pix_addr, vga_clk, hsync_n, vsync_n, blank_n,
        output red, green, blue, frame_start, col, row
    );

    modport slave (
        output pix_data,
        input  pix_addr, vga_clk, hsync_n, vsync_n, blank_n,
        input  red, green, blue, frame_start, col, row
    );

endinterface

// File: rtl/vga_sync_counter.sv
// Pixel enable, horizontal/vertical position counters and the frame-start pulse.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int unsigned VVis  = V_VIS,
    parameter int unsigned VFp   = V_FP,
    parameter int unsigned VSync = V_SYNC,
    parameter int unsigned VBp   = V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pe_o,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             h_wrap_o,
    output logic             v_wrap_o,
    output logic             frame_start_o
);

    localparam logic [CNT_W-1:0] HLast = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(VVis + VFp + VSync + VBp - 1);

    logic             pe_q, pe_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_wrap, v_wrap;

    assign h_wrap = (h_q == HLast);
    assign v_wrap = (v_q == VLast);

    always_comb begin
        pe_d = ~pe_q;
        h_d  = h_q;
        v_d  = v_q;
        if (pe_q) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pe_q <= 1'b0;
            h_q  <= '0;
            v_q  <= '0;
        end else begin
            pe_q <= pe_d;
            h_q  <= h_d;
            v_q  <= v_d;
        end
    end

    assign pe_o          = pe_q;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign h_wrap_o      = h_wrap;
    assign v_wrap_o      = v_wrap;
    assign frame_start_o = pe_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_frame_fetch.sv
// VGA frame fetcher: walks a row-major window of the framebuffer and drives registered
// RGB/sync/blank outputs one pixel behind the counters, covering the memory read latency.
module vga_frame_fetch
    import vga_pkg::*;
#(
    parameter int unsigned WinW  = WIN_W,
    parameter int unsigned WinH  = WIN_H,
    parameter int unsigned VVis  = V_VIS,
    parameter int unsigned VFp   = V_FP,
    parameter int unsigned VSync = V_SYNC,
    parameter int unsigned VBp   = V_BP
) (
    input  logic               clk,
    input  logic               reset,
    vga_frame_fetch_if.master  bus_io
);

    if (WinW > H_VIS || WinH > VVis) begin : g_bad_window
        $error("framebuffer window exceeds the visible area");
    end

    localparam logic [CNT_W-1:0]  HVisC       = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0]  HSyncStartC = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0]  HSyncEndC   = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0]  VVisC       = CNT_W'(VVis);
    localparam logic [CNT_W-1:0]  VSyncStartC = CNT_W'(VVis + VFp);
    localparam logic [CNT_W-1:0]  VSyncEndC   = CNT_W'(VVis + VFp + VSync - 1);
    localparam logic [CNT_W-1:0]  WinWC       = CNT_W'(WinW);
    localparam logic [CNT_W-1:0]  WinHC       = CNT_W'(WinH);
    localparam logic [ADDR_W-1:0] WinWA       = ADDR_W'(WinW);

    logic             pe;
    logic [CNT_W-1:0] h, v;
    logic             h_wrap, v_wrap;
    logic             frame_start;

    vga_sync_counter #(
        .VVis  (VVis),
        .VFp   (VFp),
        .VSync (VSync),
        .VBp   (VBp)
    ) u_sync_counter (
        .clk           (clk),
        .reset         (reset),
        .pe_o          (pe),
        .h_o           (h),
        .v_o           (v),
        .h_wrap_o      (h_wrap),
        .v_wrap_o      (v_wrap),
        .frame_start_o (frame_start)
    );

    logic              in_win;
    logic [ADDR_W-1:0] line_base_q, line_base_d;

    assign in_win = !reset && (h < WinWC) && (v < WinHC);

    always_comb begin
        line_base_d = line_base_q;
        if (pe && h_wrap) begin
            if (v_wrap) begin
                line_base_d = '0;
            end else if (v < WinHC) begin
                line_base_d = line_base_q + WinWA;
            end
        end
    end

    assign bus_io.pix_addr = in_win ? (line_base_q + ADDR_W'(h)) : ADDR_NONE;

    logic hs_act, vs_act, visible;

    assign hs_act  = in_span(h, HSyncStartC, HSyncEndC);
    assign vs_act  = in_span(v, VSyncStartC, VSyncEndC);
    assign visible = (h < HVisC) && (v < VVisC);

    rgb_t rgb_q, rgb_d;
    logic hsync_n_q, hsync_n_d;
    logic vsync_n_q, vsync_n_d;
    logic blank_n_q, blank_n_d;

    // Read data for the current pixel arrives in its pe cycle; capture it alongside
    // the same pixel's decode so every DAC output lags the counters by one pixel.
    always_comb begin
        rgb_d     = rgb_q;
        hsync_n_d = hsync_n_q;
        vsync_n_d = vsync_n_q;
        blank_n_d = blank_n_q;
        if (pe) begin
            rgb_d     = in_win ? rgb_t'(bus_io.pix_data[23:0]) : '0;
            hsync_n_d = ~hs_act;
            vsync_n_d = ~vs_act;
            blank_n_d = visible;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_base_q <= '0;
            rgb_q       <= '0;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
            blank_n_q   <= 1'b0;
        end else begin
            line_base_q <= line_base_d;
            rgb_q       <= rgb_d;
            hsync_n_q   <= hsync_n_d;
            vsync_n_q   <= vsync_n_d;
            blank_n_q   <= blank_n_d;
        end
    end

    logic unused_top_byte;
    assign unused_top_byte = ^bus_io.pix_data[31:24];

    assign bus_io.vga_clk     = pe;
    assign bus_io.hsync_n     = hsync_n_q;
    assign bus_io.vsync_n     = vsync_n_q;
    assign bus_io.blank_n     = blank_n_q;
    assign bus_io.red         = rgb_q.red;
    assign bus_io.green       = rgb_q.green;
    assign bus_io.blue        = rgb_q.blue;
    assign bus_io.frame_start = frame_start;
    assign bus_io.col         = h;
    assign bus_io.row         = v;

endmodule
